// File: rtl/mem_lsu_if.sv
// Data-bus bundle between the memory-stage LSU (master) and data memory (slave).
// dbus_req stays high until a single-cycle dbus_ack; dbus_rdata is valid only while dbus_ack is high.
interface mem_lsu_if;
   logic        dbus_req;
   logic        dbus_we;
   logic [31:0] dbus_addr;
   logic [3:0]  dbus_sel;
   logic [31:0] dbus_wdata;
   logic [31:0] dbus_rdata;
   logic        dbus_ack;

   modport master (
      output dbus_req, dbus_we, dbus_addr, dbus_sel, dbus_wdata,
      input  dbus_rdata, dbus_ack
   );

   modport slave (
      input  dbus_req, dbus_we, dbus_addr, dbus_sel, dbus_wdata,
      output dbus_rdata, dbus_ack
   );
endinterface

// File: rtl/mem_lsu.sv
// Memory-stage load/store unit: runs one big-endian data access per memory op over a
// req/ack bus, stalls the pipeline while it is outstanding, and feeds MEM/WB.
module mem_lsu #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  mem_wd,
   input  logic        mem_wreg,
   input  logic [31:0] mem_wdata,
   input  logic [31:0] mem_hi,
   input  logic [31:0] mem_lo,
   input  logic        mem_whilo,
   input  logic [7:0]  mem_aluop,
   input  logic [31:0] mem_mem_addr,
   input  logic [31:0] mem_reg2,
   input  logic [5:0]  stall,
   output logic [4:0]  wb_wd,
   output logic        wb_wreg,
   output logic [31:0] wb_wdata,
   output logic [31:0] wb_hi,
   output logic [31:0] wb_lo,
   output logic        wb_whilo,
   output logic        stallreq,
   mem_lsu_if.master   dbus,
   output logic        lsu_err,
   output logic [1:0]  o_dbg_state
);
   localparam logic [7:0] OP_LB  = 8'b1110_0000;
   localparam logic [7:0] OP_LH  = 8'b1110_0001;
   localparam logic [7:0] OP_LW  = 8'b1110_0011;
   localparam logic [7:0] OP_LBU = 8'b1110_0100;
   localparam logic [7:0] OP_LHU = 8'b1110_0101;
   localparam logic [7:0] OP_SB  = 8'b1110_1000;
   localparam logic [7:0] OP_SH  = 8'b1110_1001;
   localparam logic [7:0] OP_SW  = 8'b1110_1011;
   localparam logic [7:0] LP_TO_LAST = 8'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUS = 2'd1, S_DONE = 2'd2} state_t;

   state_t      r_state, w_state_nxt;
   logic        r_req, r_we, r_err, r_abort, r_sext;
   logic [31:0] r_addr, r_wdata, r_buf;
   logic [3:0]  r_sel;
   logic [7:0]  r_cnt;
   logic [1:0]  r_size, r_off;

   logic        w_is_load, w_is_store, w_sext, w_mem_op, w_misalign, w_legal, w_go;
   logic [1:0]  w_size;
   logic [3:0]  w_sel;
   logic [31:0] w_st_data, w_rd_ext;
   logic [7:0]  w_rd_byte;
   logic [15:0] w_rd_half;
   logic        w_unused;

   assign w_unused = ^{stall[5], stall[3:0]};

   // w_size: 0 = byte, 1 = halfword, 2 = word
   always_comb begin
      w_is_load  = 1'b0;
      w_is_store = 1'b0;
      w_size     = 2'd0;
      w_sext     = 1'b0;
      case (mem_aluop)
         OP_LB:   begin w_is_load = 1'b1;  w_size = 2'd0; w_sext = 1'b1; end
         OP_LBU:  begin w_is_load = 1'b1;  w_size = 2'd0; end
         OP_LH:   begin w_is_load = 1'b1;  w_size = 2'd1; w_sext = 1'b1; end
         OP_LHU:  begin w_is_load = 1'b1;  w_size = 2'd1; end
         OP_LW:   begin w_is_load = 1'b1;  w_size = 2'd2; end
         OP_SB:   begin w_is_store = 1'b1; w_size = 2'd0; end
         OP_SH:   begin w_is_store = 1'b1; w_size = 2'd1; end
         OP_SW:   begin w_is_store = 1'b1; w_size = 2'd2; end
         default: ;
      endcase
   end

   assign w_mem_op   = w_is_load | w_is_store;
   assign w_misalign = ((w_size == 2'd1) && mem_mem_addr[0]) ||
                       ((w_size == 2'd2) && (mem_mem_addr[1:0] != 2'b00));
   assign w_legal    = w_mem_op & ~w_misalign;
   assign w_go       = (r_state == S_IDLE) && w_legal && !stall[4];

   always_comb begin
      w_sel     = 4'b1111;
      w_st_data = mem_reg2;
      case (w_size)
         2'd0: begin
            w_sel     = 4'b1000 >> mem_mem_addr[1:0];
            w_st_data = {4{mem_reg2[7:0]}};
         end
         2'd1: begin
            w_sel     = mem_mem_addr[1] ? 4'b0011 : 4'b1100;
            w_st_data = {2{mem_reg2[15:0]}};
         end
         default: ;
      endcase
   end

   // Lane extraction uses the offset/size latched at launch, not the live inputs.
   always_comb begin
      case (r_off)
         2'd0:    w_rd_byte = dbus.dbus_rdata[31:24];
         2'd1:    w_rd_byte = dbus.dbus_rdata[23:16];
         2'd2:    w_rd_byte = dbus.dbus_rdata[15:8];
         default: w_rd_byte = dbus.dbus_rdata[7:0];
      endcase
      w_rd_half = r_off[1] ? dbus.dbus_rdata[15:0] : dbus.dbus_rdata[31:16];
      case (r_size)
         2'd0:    w_rd_ext = r_sext ? {{24{w_rd_byte[7]}}, w_rd_byte} : {24'h0, w_rd_byte};
         2'd1:    w_rd_ext = r_sext ? {{16{w_rd_half[15]}}, w_rd_half} : {16'h0, w_rd_half};
         default: w_rd_ext = dbus.dbus_rdata;
      endcase
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_go) w_state_nxt = S_BUS;
         S_BUS:   if (dbus.dbus_ack || (r_cnt == LP_TO_LAST)) w_state_nxt = S_DONE;
         S_DONE:  if (!stall[4]) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_req   <= 1'b0;
         r_we    <= 1'b0;
         r_addr  <= 32'h0;
         r_wdata <= 32'h0;
         r_sel   <= 4'h0;
         r_buf   <= 32'h0;
         r_cnt   <= 8'h0;
         r_err   <= 1'b0;
         r_abort <= 1'b0;
         r_size  <= 2'd0;
         r_off   <= 2'd0;
         r_sext  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_err   <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_go) begin
                  r_req   <= 1'b1;
                  r_we    <= w_is_store;
                  r_addr  <= {mem_mem_addr[31:2], 2'b00};
                  r_sel   <= w_sel;
                  r_wdata <= w_st_data;
                  r_cnt   <= 8'h0;
                  r_abort <= 1'b0;
                  r_size  <= w_size;
                  r_off   <= mem_mem_addr[1:0];
                  r_sext  <= w_sext;
               end else if (w_mem_op && w_misalign && !stall[4]) begin
                  r_err <= 1'b1;
               end
            end
            S_BUS: begin
               if (dbus.dbus_ack) begin
                  r_req <= 1'b0;
                  r_buf <= w_rd_ext;
               end else if (r_cnt == LP_TO_LAST) begin
                  r_req   <= 1'b0;
                  r_err   <= 1'b1;
                  r_abort <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

   // Write-back defaults to pass-through; memory ops override enable/data by state.
   always_comb begin
      wb_wd    = mem_wd;
      wb_wreg  = mem_wreg;
      wb_wdata = mem_wdata;
      wb_hi    = mem_hi;
      wb_lo    = mem_lo;
      wb_whilo = mem_whilo;
      stallreq = 1'b0;
      if (!rst) begin
         wb_wd    = 5'h0;
         wb_wreg  = 1'b0;
         wb_wdata = 32'h0;
         wb_hi    = 32'h0;
         wb_lo    = 32'h0;
         wb_whilo = 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_mem_op) begin
                  wb_wreg  = 1'b0;
                  stallreq = w_legal & ~stall[4];
               end
            end
            S_BUS: begin
               wb_wreg  = 1'b0;
               stallreq = 1'b1;
            end
            S_DONE: begin
               if (!r_we) begin
                  wb_wdata = r_buf;
                  wb_wreg  = mem_wreg & ~r_abort;
               end else begin
                  wb_wreg = 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign dbus.dbus_req   = r_req;
   assign dbus.dbus_we    = r_we;
   assign dbus.dbus_addr  = r_addr;
   assign dbus.dbus_sel   = r_sel;
   assign dbus.dbus_wdata = r_wdata;
   assign lsu_err         = r_err;
   assign o_dbg_state     = r_state;
endmodule
